// File: rtl/inst_encoder.sv
// inst_encoder: packs RISC-V style field bundles into 32-bit instruction words
// behind a one-stage valid/ready register, assigning sequential word addresses.
module inst_encoder #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_err,
  input  logic        addr_clr,
  output logic [7:0]  err_cnt
);
  logic        r_valid, r_err;
  logic [31:0] r_inst, r_addr, r_cnt;
  logic [7:0]  r_err_cnt;
  logic        w_acc, w_err;
  logic [31:0] w_inst, w_base;
  assign in_ready = !r_valid || out_ready;
  assign w_acc    = in_valid && in_ready;
  assign w_base   = addr_clr ? RESET_ADDR : r_cnt;
  // fmt=7 falls through to the NOP word with the error flag raised
  always_comb begin
    w_inst = 32'h0000_0013;
    w_err  = 1'b1;
    case (fmt)
      3'd0: begin
        w_inst = {func7, rs2, rs1, func3, rd, opcode};
        w_err  = 1'b0;
      end
      3'd1: begin
        w_inst = {imm[11:0], rs1, func3, rd, opcode};
        w_err  = !(&imm[31:11] || ~|imm[31:11]);
      end
      3'd2: begin
        w_inst = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
        w_err  = !(&imm[31:11] || ~|imm[31:11]);
      end
      3'd3: begin
        w_inst = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
        w_err  = !(&imm[31:12] || ~|imm[31:12]) || imm[0];
      end
      3'd4: begin
        w_inst = {imm[19:0], rd, opcode};
        w_err  = |imm[31:20];
      end
      3'd5: begin
        w_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        w_err  = !(&imm[31:20] || ~|imm[31:20]) || imm[0];
      end
      3'd6: begin
        w_inst = {func7, imm[4:0], rs1, func3, rd, opcode};
        w_err  = |imm[31:5];
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_inst    <= '0;
      r_addr    <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_cnt     <= RESET_ADDR;
    end else begin
      if (w_acc) begin
        r_valid <= 1'b1;
        r_inst  <= w_inst;
        r_addr  <= w_base;
        r_err   <= w_err;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      r_cnt <= w_acc ? w_base + 32'd4 : w_base;
      if (w_acc && w_err && r_err_cnt != 8'hff)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end
  assign out_valid = r_valid;
  assign out_inst  = r_inst;
  assign out_addr  = r_addr;
  assign out_err   = r_err;
  assign err_cnt   = r_err_cnt;
endmodule
